// File: rtl/add_pkg.sv
// Shared opcode encoding for the pipelined adder/subtractor.
package add_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/add_slice.sv
// One SL-bit slice of the pipelined adder: registered sum and carry-out,
// updated only when the global advance enable is high.
module add_slice #(
  parameter int SL = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [SL-1:0] a,
  input  logic [SL-1:0] b,
  input  logic          ci,
  output logic [SL-1:0] s,
  output logic          co
);
  logic [SL:0]   sum_d;
  logic [SL-1:0] s_q;
  logic          co_q;

  assign sum_d = {1'b0, a} + {1'b0, b} + {{SL{1'b0}}, ci};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= '0;
      co_q <= 1'b0;
    end else if (en) begin
      s_q  <= sum_d[SL-1:0];
      co_q <= sum_d[SL];
    end
  end

  assign s  = s_q;
  assign co = co_q;
endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor: STAGES slices with registered carries,
// operand skew and result de-skew registers, and one global stall enable.
module pipe_adder
  import add_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SL = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] bp;
  logic             a_msb_q;
  logic             bp_msb_q;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign bp       = (op == OP_SUB) ? ~b : b;

  for (genvar gi = 0; gi < STAGES; gi++) begin : stg
    // a_in/b_in hold the operand bits from slice gi upward as seen by this stage
    localparam int IW = WIDTH - gi * SL;
    logic [IW-1:0]         a_in;
    logic [IW-1:0]         b_in;
    logic                  ci;
    logic                  vin;
    logic                  vld_q;
    logic [SL-1:0]         s;
    logic                  co;
    logic [(gi+1)*SL-1:0]  acc;

    if (gi == 0) begin : g_head
      assign a_in = a;
      assign b_in = bp;
      assign ci   = cin;
      assign vin  = in_valid;
      assign acc  = s;
    end else begin : g_tail
      logic [gi*SL-1:0] lo_q;
      assign a_in = stg[gi-1].g_fwd.a_fwd_q;
      assign b_in = stg[gi-1].g_fwd.b_fwd_q;
      assign ci   = stg[gi-1].co;
      assign vin  = stg[gi-1].vld_q;
      assign acc  = {s, lo_q};
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   lo_q <= '0;
        else if (adv) lo_q <= stg[gi-1].acc;
      end
    end

    if (gi < STAGES - 1) begin : g_fwd
      logic [IW-SL-1:0] a_fwd_q;
      logic [IW-SL-1:0] b_fwd_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_fwd_q <= '0;
          b_fwd_q <= '0;
        end else if (adv) begin
          a_fwd_q <= a_in[IW-1:SL];
          b_fwd_q <= b_in[IW-1:SL];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   vld_q <= 1'b0;
      else if (adv) vld_q <= vin;
    end

    add_slice #(.SL(SL)) u_slice (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (adv),
      .a    (a_in[SL-1:0]),
      .b    (b_in[SL-1:0]),
      .ci   (ci),
      .s    (s),
      .co   (co)
    );
  end

  // Operand sign bits travel alongside the top slice so ovf comes from registers only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q  <= 1'b0;
      bp_msb_q <= 1'b0;
    end else if (adv) begin
      a_msb_q  <= stg[STAGES-1].a_in[SL-1];
      bp_msb_q <= stg[STAGES-1].b_in[SL-1];
    end
  end

  assign out_valid = stg[STAGES-1].vld_q;
  assign sum       = stg[STAGES-1].acc;
  assign cout      = stg[STAGES-1].co;
  assign ovf       = (a_msb_q == bp_msb_q) && (sum[WIDTH-1] != a_msb_q);
endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder in three configurations (8/2, 16/4, 8/1)
// against an arithmetic reference model.
module tb_pipe_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic v8, ir8, cin8, op8, ov8, or8, co8, of8;
  logic [7:0] a8, b8, s8;
  logic v16, ir16, cin16, op16, ov16, or16, co16, of16;
  logic [15:0] a16, b16, s16;
  logic v1, ir1, cin1, op1, ov1, or1, co1, of1;
  logic [7:0] a1, b1, s1;

  pipe_adder #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .op(op8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8));
  pipe_adder #(.WIDTH(16), .STAGES(4)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .op(op16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(of16));
  pipe_adder #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .op(op1), .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .ovf(of1));

  // Returns {ovf, cout, sum[15:0]} using integer arithmetic on w-bit operands.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic op);
    longint m, half, ua, ub, tot, sa, sb, sv;
    logic [15:0] sm;
    logic c, o;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a);
    ub   = longint'(b);
    if (op) ub = (~ub) & m;
    tot  = ua + ub + longint'(cin);
    sm   = 16'(tot & m);
    c    = ((tot >> w) & 1) != 0;
    sa   = (ua >= half) ? ua - (m + 1) : ua;
    sb   = (ub >= half) ? ub - (m + 1) : ub;
    sv   = sa + sb + longint'(cin);
    o    = (sv >= half) || (sv < -half);
    return {o, c, sm};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", ov8); end
    checks++; if (s8 !== 8'h00) begin errors++; $display("FAIL reset sum: got %h want 00", s8); end
    checks++; if (co8 !== 1'b0 || of8 !== 1'b0) begin errors++; $display("FAIL reset cout/ovf: got %b%b want 00", co8, of8); end
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", ir8); end
    checks++; if (ov16 !== 1'b0 || ov1 !== 1'b0) begin errors++; $display("FAIL reset out_valid w16/s1: got %b%b want 00", ov16, ov1); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ov8 !== 1'b0 || s8 !== 8'h00) begin errors++; $display("FAIL idle after reset: got v=%b s=%h want 0/00", ov8, s8); end
  endtask

  task automatic test_directed();
    logic [7:0]  ta[3] = '{8'hFF, 8'h05, 8'h7F};
    logic [7:0]  tb[3] = '{8'h00, 8'h07, 8'h01};
    logic        tc[3] = '{1'b1, 1'b1, 1'b0};
    logic        to[3] = '{1'b0, 1'b1, 1'b0};
    logic [17:0] e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a8 = ta[i]; b8 = tb[i]; cin8 = tc[i]; op8 = to[i]; v8 = 1'b1;
      e = model(8, {8'h00, ta[i]}, {8'h00, tb[i]}, tc[i], to[i]);
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        v8 = 1'b0;
        checks++;
        if (ov8 !== (k == 2)) begin errors++; $display("FAIL directed%0d out_valid after %0d edges: got %b want %b", i, k, ov8, k == 2); end
        if (k == 2) begin
          checks++;
          if ({of8, co8, s8} !== {e[17:16], e[7:0]})
            begin errors++; $display("FAIL directed%0d result: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h", i, of8, co8, s8, e[17], e[16], e[7:0]); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] q[$];
    logic [17:0] e;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (ov8 !== (k >= 2 && k < 18)) begin errors++; $display("FAIL b2b out_valid cycle %0d: got %b want %b", k, ov8, (k >= 2 && k < 18)); end
      if (k >= 2 && k < 18) begin
        e = q.pop_front();
        checks++;
        if ({of8, co8, s8} !== {e[17:16], e[7:0]})
          begin errors++; $display("FAIL b2b beat %0d: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h", k - 2, of8, co8, s8, e[17], e[16], e[7:0]); end
      end
      if (k < 16) begin
        a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
        cin8 = 1'($urandom_range(0, 1)); op8 = 1'($urandom_range(0, 1)); v8 = 1'b1;
        q.push_back(model(8, {8'h00, a8}, {8'h00, b8}, cin8, op8));
      end else v8 = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] q[$];
    logic [17:0] e;
    logic [9:0]  held;
    int sent = 0, recv = 0;
    logic need_new = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      or8 = !(c >= 6 && c < 11);
      if (need_new && sent < 12) begin
        a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
        cin8 = 1'($urandom_range(0, 1)); op8 = 1'($urandom_range(0, 1));
        need_new = 1'b0;
      end
      v8 = (sent < 12);
      #1;
      if (c == 6) held = {of8, co8, s8};
      if (c >= 7 && c < 11) begin
        checks++;
        if (ov8 !== 1'b1 || ir8 !== 1'b0) begin errors++; $display("FAIL stall cycle %0d: got out_valid=%b in_ready=%b want 1/0", c, ov8, ir8); end
        checks++;
        if ({of8, co8, s8} !== held) begin errors++; $display("FAIL stall hold cycle %0d: got %h want %h", c, {of8, co8, s8}, held); end
      end
      if (ov8 && or8) begin
        recv++;
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL stall extra beat: got a result with none outstanding"); end
        else begin
          e = q.pop_front();
          if ({of8, co8, s8} !== {e[17:16], e[7:0]})
            begin errors++; $display("FAIL stall beat %0d: got %h want %h", recv - 1, {of8, co8, s8}, {e[17:16], e[7:0]}); end
        end
      end
      if (v8 && ir8) begin
        q.push_back(model(8, {8'h00, a8}, {8'h00, b8}, cin8, op8));
        sent++;
        need_new = 1'b1;
      end
    end
    v8 = 1'b0; or8 = 1'b1;
    checks++;
    if (recv !== 12 || q.size() !== 0) begin errors++; $display("FAIL stall count: got %0d results, %0d pending want 12, 0", recv, q.size()); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
      cin8 = 1'b0; op8 = 1'b0; v8 = 1'b1;
    end
    #1;
    checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL pre-reset out_valid: got %b want 1", ov8); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL async reset out_valid: got %b want 0", ov8); end
    checks++; if ({of8, co8, s8} !== 10'h000) begin errors++; $display("FAIL async reset data: got %h want 000", {of8, co8, s8}); end
    v8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL stale beat after reset cycle %0d: got out_valid %b want 0", k, ov8); end
    end
  endtask

  task automatic test_w16();
    logic [17:0] q[$];
    logic [17:0] e;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (ov16 !== (k >= 4 && k < 14)) begin errors++; $display("FAIL w16 out_valid cycle %0d: got %b want %b", k, ov16, (k >= 4 && k < 14)); end
      if (k >= 4 && k < 14) begin
        e = q.pop_front();
        checks++;
        if ({of16, co16, s16} !== e) begin errors++; $display("FAIL w16 beat %0d: got %h want %h", k - 4, {of16, co16, s16}, e); end
      end
      if (k < 10) begin
        if (k == 0) begin a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; op16 = 1'b0; end
        else begin
          a16 = 16'($urandom_range(0, 65535)); b16 = 16'($urandom_range(0, 65535));
          cin16 = 1'($urandom_range(0, 1)); op16 = 1'($urandom_range(0, 1));
        end
        v16 = 1'b1;
        q.push_back(model(16, a16, b16, cin16, op16));
      end else v16 = 1'b0;
    end
  endtask

  task automatic test_s1();
    logic [17:0] q[$];
    logic [17:0] e;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (ov1 !== (k >= 1 && k < 11)) begin errors++; $display("FAIL s1 out_valid cycle %0d: got %b want %b", k, ov1, (k >= 1 && k < 11)); end
      if (k >= 1 && k < 11) begin
        e = q.pop_front();
        checks++;
        if ({of1, co1, s1} !== {e[17:16], e[7:0]})
          begin errors++; $display("FAIL s1 beat %0d: got %h want %h", k - 1, {of1, co1, s1}, {e[17:16], e[7:0]}); end
      end
      if (k < 10) begin
        if (k == 0) begin a1 = 8'hFF; b1 = 8'h01; cin1 = 1'b0; op1 = 1'b0; end
        else begin
          a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
          cin1 = 1'($urandom_range(0, 1)); op1 = 1'($urandom_range(0, 1));
        end
        v1 = 1'b1;
        q.push_back(model(8, {8'h00, a1}, {8'h00, b1}, cin1, op1));
      end else v1 = 1'b0;
    end
  endtask

  initial begin
    v8 = 0; a8 = 0; b8 = 0; cin8 = 0; op8 = 0; or8 = 1;
    v16 = 0; a16 = 0; b16 = 0; cin16 = 0; op16 = 0; or16 = 1;
    v1 = 0; a1 = 0; b1 = 0; cin1 = 0; op1 = 0; or1 = 1;
    test_reset();
    test_directed();
    repeat (3) @(negedge clk);
    test_back_to_back();
    repeat (3) @(negedge clk);
    test_backpressure();
    repeat (3) @(negedge clk);
    test_async_reset();
    test_w16();
    test_s1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
